// File: rtl/cc_level_pkg.sv
// Shared definitions for the P1/P2 level sequencers and level managers:
// level codes, default level lengths and sequencer state encoding.
package cc_level_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2,
        ST_WIN  = 2'd3
    } seq_state_t;

    localparam logic [2:0] LVL_NONE = 3'd0;
    localparam logic [2:0] LVL_1    = 3'd2;
    localparam logic [2:0] LVL_2    = 3'd4;
    localparam logic [2:0] LVL_3    = 3'd6;

    localparam int LV1_LEN_DEFAULT  = 10;
    localparam int LV2_LEN_DEFAULT  = 15;
    localparam int LV3_LEN_DEFAULT  = 20;
    localparam int GAP_ROWS_DEFAULT = 4;

    localparam int ROW_W = 8;

    // Row count of the level selected by a level code; 0 for "no level".
    function automatic logic [4:0] level_len(input logic [2:0] code,
                                             input logic [4:0] l1,
                                             input logic [4:0] l2,
                                             input logic [4:0] l3);
        case (code)
            LVL_1:   return l1;
            LVL_2:   return l2;
            LVL_3:   return l3;
            default: return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/cc_row_capture.sv
// Row pattern holding register: loads the level manager's pattern on request
// and pulses valid for the single cycle in which the new pattern appears.
module cc_row_capture
    import cc_level_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [ROW_W-1:0] din,
    output logic [ROW_W-1:0] row,
    output logic             valid
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row   <= '0;
            valid <= 1'b0;
        end else begin
            valid <= load;
            if (load) begin
                row <= din;
            end
        end
    end

endmodule

// File: rtl/cc_level_sequencer_p2.sv
// P2 level sequencer: walks levels 1..3 row by row on scroll ticks, with a
// blank gap between levels, and raises Win after the final gap.
module cc_level_sequencer_p2
    import cc_level_pkg::*;
#(
    parameter int LV1_LEN  = LV1_LEN_DEFAULT,
    parameter int LV2_LEN  = LV2_LEN_DEFAULT,
    parameter int LV3_LEN  = LV3_LEN_DEFAULT,
    parameter int GAP_ROWS = GAP_ROWS_DEFAULT
) (
    input  logic       CC_LEVEL_SEQUENCER_P2_CLOCK_50,
    input  logic       CC_LEVEL_SEQUENCER_P2_RESET_InHigh,
    input  logic       CC_LEVEL_SEQUENCER_P2_Start,
    input  logic       CC_LEVEL_SEQUENCER_P2_Tick,
    input  logic       CC_LEVEL_SEQUENCER_P2_Pause,
    input  logic [7:0] CC_LEVEL_SEQUENCER_P2_Lv_InBus,
    output logic [4:0] CC_LEVEL_SEQUENCER_P2_Progress,
    output logic [2:0] CC_LEVEL_SEQUENCER_P2_Current,
    output logic [7:0] CC_LEVEL_SEQUENCER_P2_Row_OutBus,
    output logic       CC_LEVEL_SEQUENCER_P2_RowValid,
    output logic       CC_LEVEL_SEQUENCER_P2_LevelDone,
    output logic       CC_LEVEL_SEQUENCER_P2_Win,
    output logic [1:0] dbg_state
);

    logic clk;
    logic rst;
    assign clk = CC_LEVEL_SEQUENCER_P2_CLOCK_50;
    assign rst = CC_LEVEL_SEQUENCER_P2_RESET_InHigh;

    seq_state_t state_q, state_d;
    logic [4:0] prog_q, prog_d;
    logic [2:0] cur_q, cur_d;
    logic [2:0] gap_q, gap_d;
    logic       done_q, done_d;
    logic       row_req_q, row_req_d;
    logic       tick_ok;
    logic [4:0] cur_len;

    // Start and Tick are single-cycle strobes sampled on the rising edge;
    // there is no back-pressure, a strobe not acted on in its cycle is lost.
    assign tick_ok = CC_LEVEL_SEQUENCER_P2_Tick && !CC_LEVEL_SEQUENCER_P2_Pause;
    assign cur_len = level_len(cur_q, 5'(LV1_LEN), 5'(LV2_LEN), 5'(LV3_LEN));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            prog_q    <= 5'd0;
            cur_q     <= LVL_NONE;
            gap_q     <= 3'd0;
            done_q    <= 1'b0;
            row_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            prog_q    <= prog_d;
            cur_q     <= cur_d;
            gap_q     <= gap_d;
            done_q    <= done_d;
            row_req_q <= row_req_d;
        end
    end

    always_comb begin
        state_d = state_q;
        prog_d  = prog_q;
        cur_d   = cur_q;
        gap_d   = gap_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE, ST_WIN: begin
                if (CC_LEVEL_SEQUENCER_P2_Start) begin
                    state_d = ST_RUN;
                    cur_d   = LVL_1;
                    prog_d  = 5'd0;
                    gap_d   = 3'd0;
                end
            end
            ST_RUN: begin
                if (tick_ok) begin
                    // The tick after the last row closes the level.
                    if (prog_q == cur_len) begin
                        prog_d  = 5'd0;
                        gap_d   = 3'd0;
                        state_d = ST_GAP;
                        done_d  = 1'b1;
                    end else begin
                        prog_d = prog_q + 5'd1;
                    end
                end
            end
            ST_GAP: begin
                if (tick_ok) begin
                    gap_d = gap_q + 3'd1;
                    if (gap_d == 3'(GAP_ROWS)) begin
                        if (cur_q == LVL_3) begin
                            cur_d   = LVL_NONE;
                            state_d = ST_WIN;
                        end else begin
                            cur_d   = cur_q + 3'd2;
                            state_d = ST_RUN;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        row_req_d = (prog_d != prog_q) && (prog_d != 5'd0);
    end

    // Lv_InBus answers the Progress/Current registered on the previous edge,
    // so the capture runs one edge behind the Progress update.
    cc_row_capture u_row_capture (
        .clk   (clk),
        .rst   (rst),
        .load  (row_req_q),
        .din   (CC_LEVEL_SEQUENCER_P2_Lv_InBus),
        .row   (CC_LEVEL_SEQUENCER_P2_Row_OutBus),
        .valid (CC_LEVEL_SEQUENCER_P2_RowValid)
    );

    assign CC_LEVEL_SEQUENCER_P2_Progress  = prog_q;
    assign CC_LEVEL_SEQUENCER_P2_Current   = cur_q;
    assign CC_LEVEL_SEQUENCER_P2_LevelDone = done_q;
    assign CC_LEVEL_SEQUENCER_P2_Win       = (state_q == ST_WIN);
    assign dbg_state                       = state_q;

endmodule

// File: tb/tb_cc_level_sequencer_p2.sv
// Bench for cc_level_sequencer_p2: tick-count model checked every cycle plus
// directed scenarios with hand-computed expectations.
module tb_cc_level_sequencer_p2;

    localparam int L1  = 10;
    localparam int L2  = 15;
    localparam int L3  = 20;
    localparam int GAP = 4;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start = 1'b0;
    logic       tick  = 1'b0;
    logic       pause = 1'b0;
    logic [7:0] lv_in;
    logic [4:0] dut_prog;
    logic [2:0] dut_cur;
    logic [7:0] dut_row;
    logic       dut_rv;
    logic       dut_done;
    logic       dut_win;
    logic [1:0] dut_state;

    int n_vec = 0;
    int n_err = 0;

    cc_level_sequencer_p2 dut (
        .CC_LEVEL_SEQUENCER_P2_CLOCK_50    (clk),
        .CC_LEVEL_SEQUENCER_P2_RESET_InHigh(rst),
        .CC_LEVEL_SEQUENCER_P2_Start       (start),
        .CC_LEVEL_SEQUENCER_P2_Tick        (tick),
        .CC_LEVEL_SEQUENCER_P2_Pause       (pause),
        .CC_LEVEL_SEQUENCER_P2_Lv_InBus    (lv_in),
        .CC_LEVEL_SEQUENCER_P2_Progress    (dut_prog),
        .CC_LEVEL_SEQUENCER_P2_Current     (dut_cur),
        .CC_LEVEL_SEQUENCER_P2_Row_OutBus  (dut_row),
        .CC_LEVEL_SEQUENCER_P2_RowValid    (dut_rv),
        .CC_LEVEL_SEQUENCER_P2_LevelDone   (dut_done),
        .CC_LEVEL_SEQUENCER_P2_Win         (dut_win),
        .dbg_state                         (dut_state)
    );

    // Stand-in level manager: a fixed pattern per (level code, row).
    function automatic logic [7:0] row_pat(input int cur, input int prog);
        logic [7:0] v;
        case (cur)
            2:       v = 8'd1 << ((prog + 1) % 8);
            4:       v = 8'(prog * 6);
            6:       v = 8'(prog) ^ 8'hA5;
            default: v = 8'd0;
        endcase
        return v;
    endfunction

    assign lv_in = row_pat(int'(dut_cur), int'(dut_prog));

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: everything follows from the count of accepted ticks since Start.
    function automatic int len_of(input int lvl);
        return (lvl == 1) ? L1 : (lvl == 2) ? L2 : L3;
    endfunction

    function automatic int lvl_of(input int n);
        int r = n;
        int l = 1;
        while (l <= 3 && r >= len_of(l) + 1 + GAP) begin
            r -= len_of(l) + 1 + GAP;
            l++;
        end
        return l;
    endfunction

    function automatic int rem_of(input int n);
        int r = n;
        int l = 1;
        while (l <= 3 && r >= len_of(l) + 1 + GAP) begin
            r -= len_of(l) + 1 + GAP;
            l++;
        end
        return r;
    endfunction

    function automatic int prog_of(input int mode, input int n);
        if (mode != 1) return 0;
        return (rem_of(n) <= len_of(lvl_of(n))) ? rem_of(n) : 0;
    endfunction

    function automatic int cur_of(input int mode, input int n);
        return (mode == 1) ? 2 * lvl_of(n) : 0;
    endfunction

    int         m_mode = 0;     // 0 idle, 1 playing, 2 won
    int         m_n = 0;
    logic       m_rv_pend = 1'b0;
    logic       e_rv = 1'b0;
    logic       e_done = 1'b0;
    logic [7:0] e_row = 8'd0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_n = 0; m_rv_pend = 1'b0;
            e_rv = 1'b0; e_done = 1'b0; e_row = 8'd0;
        end else begin
            e_rv = m_rv_pend;
            if (m_rv_pend) e_row = row_pat(cur_of(m_mode, m_n), prog_of(m_mode, m_n));
            m_rv_pend = 1'b0;
            e_done = 1'b0;
            if (m_mode != 1) begin
                if (start) begin
                    m_mode = 1;
                    m_n = 0;
                end
            end else if (tick && !pause) begin
                m_n++;
                if (lvl_of(m_n) > 3) m_mode = 2;
                else if (rem_of(m_n) >= 1 && rem_of(m_n) <= len_of(lvl_of(m_n))) m_rv_pend = 1'b1;
                else if (rem_of(m_n) == len_of(lvl_of(m_n)) + 1) e_done = 1'b1;
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    int         rv_cnt = 0;
    int         done_cnt = 0;
    logic [7:0] row2 = 8'd0;

    always @(negedge clk) begin
        check("progress",  int'(dut_prog), prog_of(m_mode, m_n));
        check("current",   int'(dut_cur),  cur_of(m_mode, m_n));
        check("win",       int'(dut_win),  (m_mode == 2) ? 1 : 0);
        check("leveldone", int'(dut_done), int'(e_done));
        check("rowvalid",  int'(dut_rv),   int'(e_rv));
        check("row",       int'(dut_row),  int'(e_row));
        if (dut_rv) begin
            rv_cnt++;
            if (rv_cnt == 2) row2 = dut_row;
        end
        if (dut_done) done_cnt++;
    end

    // Driver: inputs held from posedge+1 through the next edge.
    task automatic drive(input logic s, input logic t, input logic p);
        start = s; tick = t; pause = p;
        @(posedge clk); #1;
        start = 1'b0; tick = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    int rv_snap;
    int done_snap;

    initial begin
        rst = 1'b1;
        idle(3);
        check("reset progress", int'(dut_prog), 0);
        check("reset current",  int'(dut_cur), 0);
        check("reset win",      int'(dut_win), 0);
        check("reset row",      int'(dut_row), 0);
        rst = 1'b0;
        idle(1);

        drive(1'b1, 1'b0, 1'b0);
        check("start current", int'(dut_cur), 2);
        check("start progress", int'(dut_prog), 0);
        for (int i = 1; i <= 10; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            check("lv1 progress", int'(dut_prog), i);
        end
        idle(2);
        check("lv1 rowvalid count", rv_cnt, 10);
        check("lv1 second row", int'(row2), 8'b00001000);

        drive(1'b0, 1'b1, 1'b0);
        check("lv1 end progress", int'(dut_prog), 0);
        idle(1);
        check("lv1 leveldone count", done_cnt, 1);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0);
        check("lv2 current", int'(dut_cur), 4);
        check("lv2 progress", int'(dut_prog), 0);
        drive(1'b0, 1'b1, 1'b0);
        check("lv2 row1 progress", int'(dut_prog), 1);
        idle(1);
        check("lv2 row1 pattern", int'(dut_row), 8'b00000110);

        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0);
        check("pre-pause progress", int'(dut_prog), 5);
        idle(2);
        rv_snap = rv_cnt;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b1);
            check("paused progress", int'(dut_prog), 5);
        end
        idle(2);
        pause = 1'b0;
        check("paused rowvalid", rv_cnt, rv_snap);
        drive(1'b0, 1'b1, 1'b0);
        check("post-pause progress", int'(dut_prog), 6);

        for (int i = 0; i < 39; i++) drive(1'b0, 1'b1, 1'b0);
        check("win flag", int'(dut_win), 1);
        check("win current", int'(dut_cur), 0);
        check("win leveldone count", done_cnt, 3);
        drive(1'b1, 1'b0, 1'b0);
        check("restart current", int'(dut_cur), 2);
        check("restart win", int'(dut_win), 0);

        for (int i = 0; i < 22; i++) drive(1'b0, 1'b1, 1'b0);
        check("mid lv2 progress", int'(dut_prog), 7);
        check("mid lv2 current", int'(dut_cur), 4);
        drive(1'b1, 1'b0, 1'b0);
        check("start in run progress", int'(dut_prog), 7);
        idle(2);

        #2 rst = 1'b1;
        #1;
        check("async progress", int'(dut_prog), 0);
        check("async current", int'(dut_cur), 0);
        check("async row", int'(dut_row), 0);
        check("async rowvalid", int'(dut_rv), 0);
        check("async leveldone", int'(dut_done), 0);
        check("async win", int'(dut_win), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        rv_snap = rv_cnt;
        done_snap = done_cnt;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            check("idle tick progress", int'(dut_prog), 0);
        end
        idle(2);
        check("post-reset rowvalid", rv_cnt, rv_snap);
        check("post-reset leveldone", done_cnt, done_snap);

        drive(1'b1, 1'b1, 1'b0);
        check("start+tick current", int'(dut_cur), 2);
        check("start+tick progress", int'(dut_prog), 0);
        drive(1'b0, 1'b1, 1'b0);
        check("first tick progress", int'(dut_prog), 1);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, limit 100000 time units");
        $fatal(1);
    end

endmodule
